// File: rtl/handshake_pkg.sv
// Shared constants for the handshake skid buffer: state encoding and default payload width.
package handshake_pkg;

    localparam int unsigned DataWDefault = 4;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef enum logic [1:0] {
        StEmpty = EMPTY,
        StBusy  = BUSY,
        StFull  = FULL
    } state_e;

endpackage

// File: rtl/handshake_skid.sv
// Two-entry skid buffer: fully registered valid/ready handshake, one word/cycle throughput.
// Optional stall counter output enabled by defining HANDSHAKE_SKID_STATS_EN.
module handshake_skid #(
    parameter int unsigned DATA_W = handshake_pkg::DataWDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
`ifdef HANDSHAKE_SKID_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    import handshake_pkg::*;

    state_e              state_q;
    logic [DATA_W-1:0]   main_q;
    logic [DATA_W-1:0]   skid_q;
    logic                dout_valid_q;
    logic                din_ready_q;
    logic                accept;
    logic                take;

    assign accept     = din_valid && din_ready_q;
    assign take       = dout_valid_q && dout_ready;
    assign din_ready  = din_ready_q;
    assign dout_valid = dout_valid_q;
    assign dout       = main_q;

    // Handshake outputs are kept as their own flops so neither side sees a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            main_q       <= '0;
            skid_q       <= '0;
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q      <= StBusy;
                        main_q       <= din;
                        dout_valid_q <= 1'b1;
                    end
                end
                StBusy: begin
                    if (accept && !take) begin
                        state_q     <= StFull;
                        skid_q      <= din;
                        din_ready_q <= 1'b0;
                    end else if (take && !accept) begin
                        state_q      <= StEmpty;
                        dout_valid_q <= 1'b0;
                    end else if (accept && take) begin
                        main_q <= din;
                    end
                end
                StFull: begin
                    if (take) begin
                        state_q     <= StBusy;
                        main_q      <= skid_q;
                        din_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= StEmpty;
                    dout_valid_q <= 1'b0;
                    din_ready_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef HANDSHAKE_SKID_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else if (dout_valid_q && !dout_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_handshake_skid.sv
// Directed bench for handshake_skid; stall counter checks run when HANDSHAKE_SKID_STATS_EN is set.
module tb_handshake_skid;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
`ifdef HANDSHAKE_SKID_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    handshake_skid #(.DATA_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef HANDSHAKE_SKID_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so registered outputs can be sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 4'h5;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        step();
        step();
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_din_ready", 32'(din_ready), 32'd1);

        // Single word: first accept on the first edge after release.
        rst_n     = 1'b1;
        din       = 4'h3;
        din_valid = 1'b1;
        step();
        check("single_valid", 32'(dout_valid), 32'd1);
        check("single_dout", 32'(dout), 32'h3);
        din_valid = 1'b0;
        step();
        check("single_gone", 32'(dout_valid), 32'd0);

        // Back-to-back stream at full throughput.
        for (int i = 1; i <= 8; i++) begin
            din       = 4'(i);
            din_valid = 1'b1;
            step();
            check($sformatf("stream_dout_%0d", i), 32'(dout), 32'(i));
            check($sformatf("stream_valid_%0d", i), 32'(dout_valid), 32'd1);
            check($sformatf("stream_ready_%0d", i), 32'(din_ready), 32'd1);
        end
        din_valid = 1'b0;
        step();
        check("stream_end", 32'(dout_valid), 32'd0);

        // Backpressure fills main then skid.
        dout_ready = 1'b0;
        din        = 4'hA;
        din_valid  = 1'b1;
        step();
        check("bp_a_dout", 32'(dout), 32'hA);
        check("bp_a_ready", 32'(din_ready), 32'd1);
        din = 4'hB;
        step();
        check("bp_full_ready", 32'(din_ready), 32'd0);
        check("bp_full_dout", 32'(dout), 32'hA);
        check("bp_full_valid", 32'(dout_valid), 32'd1);

        // Words offered while full must be ignored.
        din = 4'hF;
        for (int i = 0; i < 3; i++) begin
            din_valid = (i != 1);
            step();
            check($sformatf("full_ign_dout_%0d", i), 32'(dout), 32'hA);
            check($sformatf("full_ign_ready_%0d", i), 32'(din_ready), 32'd0);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        step();
        check("drain_b_dout", 32'(dout), 32'hB);
        check("drain_b_valid", 32'(dout_valid), 32'd1);
        check("drain_b_ready", 32'(din_ready), 32'd1);
        step();
        check("drain_empty", 32'(dout_valid), 32'd0);

        // Asynchronous reset while full.
        dout_ready = 1'b0;
        din        = 4'h6;
        din_valid  = 1'b1;
        step();
        din = 4'h7;
        step();
        check("pre_rst_full", 32'(din_ready), 32'd0);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("async_rst_valid", 32'(dout_valid), 32'd0);
        check("async_rst_dout", 32'(dout), 32'h0);
        check("async_rst_ready", 32'(din_ready), 32'd1);
        step();
        rst_n      = 1'b1;
        dout_ready = 1'b1;
        step();
        check("post_rst_no_stale", 32'(dout_valid), 32'd0);
        step();
        check("post_rst_still_empty", 32'(dout_valid), 32'd0);
        din       = 4'h9;
        din_valid = 1'b1;
        step();
        check("post_rst_new_dout", 32'(dout), 32'h9);
        din_valid = 1'b0;
        step();
        check("post_rst_single", 32'(dout_valid), 32'd0);

`ifdef HANDSHAKE_SKID_STATS_EN
        rst_n = 1'b0;
        step();
        check("stall_rst", 32'(stall_cnt), 32'h0);
        rst_n      = 1'b1;
        dout_ready = 1'b0;
        din        = 4'hC;
        din_valid  = 1'b1;
        step();
        din_valid = 1'b0;
        check("stall_start", 32'(stall_cnt), 32'h0);
        for (int i = 0; i < 5; i++) step();
        check("stall_five", 32'(stall_cnt), 32'd5);
        for (int i = 0; i < 65529; i++) begin
            @(posedge clk);
        end
        #1;
        check("stall_fffe", 32'(stall_cnt), 32'hFFFE);
        step();
        check("stall_ffff", 32'(stall_cnt), 32'hFFFF);
        step();
        check("stall_sat", 32'(stall_cnt), 32'hFFFF);
        dout_ready = 1'b1;
        step();
        check("stall_hold_on_take", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_skid.md
HANDSHAKE_SKID -- requirements
Module: handshake_skid

Interface
REQ-001 Parameter DATA_W, default 4, payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 din  input  DATA_W  upstream payload.
REQ-005 din_valid  input  1  upstream payload valid.
REQ-006 din_ready  output  1  block can accept; driven directly from a flop, with no combinational path from dout_ready.
REQ-007 dout  output  DATA_W  downstream payload, registered.
REQ-008 dout_valid  output  1  downstream payload valid, registered.
REQ-009 dout_ready  input  1  downstream can accept.

Function
REQ-010 accept = din_valid && din_ready; take = dout_valid && dout_ready; both are evaluated at the rising edge.
REQ-011 Two storage registers: main (drives dout) and skid (holds one word overflowed while din_ready was still 1).
REQ-012 States: EMPTY (dout_valid=0, din_ready=1), BUSY (dout_valid=1, din_ready=1), FULL (dout_valid=1, din_ready=0).
REQ-013 EMPTY: accept -> BUSY, main<=din; otherwise stay.
REQ-014 BUSY: accept&&!take -> FULL, skid<=din; take&&!accept -> EMPTY; accept&&take -> BUSY, main<=din; neither -> stay, hold.
REQ-015 FULL: take -> BUSY, main<=skid; otherwise stay, hold; din is never captured in FULL.
REQ-016 Latency din->dout is exactly 1 cycle from EMPTY; sustained throughput is 1 word/cycle with dout_ready held 1.
REQ-017 Words leave in acceptance order; none is dropped or duplicated.
REQ-018 dout and dout_valid are stable while dout_valid && !dout_ready.
REQ-019 The block ignores din whenever !din_ready, including din_valid toggling.
REQ-020 dout_valid never depends combinationally on din_valid, and din_ready never depends combinationally on dout_ready.

Reset
REQ-021 While rst_n=0: state EMPTY, dout=0, skid=0, dout_valid=0, din_ready=1; no word is captured.
REQ-022 Reset asserted mid-operation discards main and skid contents at once, whatever the state.
REQ-023 The first accept is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro HANDSHAKE_SKID_STATS_EN defined: add output stall_cnt (16 bits) that increments each cycle dout_valid && !dout_ready, saturates at 16'hFFFF, and resets to 0.
REQ-025 Macro HANDSHAKE_SKID_STATS_EN undefined: no stall_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-026 Shared package handshake_pkg holds the state encoding constants (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and the default DATA_W.
REQ-027 No sub-module; the skid buffer is a single module.

Verification
REQ-028 Reset then din=4'h3, din_valid=1 for one cycle, dout_ready=1 -> dout=4'h3, dout_valid=1 for exactly one cycle starting the next cycle.
REQ-029 Stream 4'h1..4'h8 on consecutive cycles, dout_ready=1 -> dout 4'h1..4'h8 on consecutive cycles, din_ready always 1.
REQ-030 dout_ready=0, send 4'hA then 4'hB -> din_ready=0 after 4'hB, dout holds 4'hA; raise dout_ready -> 4'hA, then 4'hB, then din_ready=1.
REQ-031 In FULL, drive din=4'hF, din_valid=1 for 3 cycles -> 4'hF never appears at dout.
REQ-032 In FULL, pulse rst_n=0 -> dout_valid=0, dout=0, din_ready=1 immediately; no stale word after release.
REQ-033 With HANDSHAKE_SKID_STATS_EN, hold dout_valid=1 with dout_ready=0 for 5 cycles -> stall_cnt=5; forced to 16'hFFFE, two more stall cycles -> 16'hFFFF.
